uart_tx_fifo: RTL and testbench

Byte FIFO that sits directly upstream of the UART transmit serializer. Host-side logic pushes bytes with a write strobe. The serializer pulls them with a one-cycle `req` pulse and samples `data` one or more cycles later. The block buffers bursts, presents a byte that stays stable after each pop, and reports fill level plus sticky error flags.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo_if.sv | 44 ++++
 rtl/uart_fifo_mem.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants and types for the UART block family (TX FIFO, serializer,
// RX side). Keeping the byte width and default FIFO depth here ensures that
// all UART blocks agree on them.
package uart_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_TX_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Bundles the host push side, the serializer pop side and the status/error
// signals of the UART transmit FIFO.
//   wr_en, wr_data   : host push strobe and byte
//   flush            : discard all stored bytes
//   req              : one-cycle pop strobe from the serializer
//   err_clr          : clears the sticky error flags
//   full             : count == DEPTH
//   data_available   : count != 0
//   data             : last popped byte, held until the next accepted pop
//   count            : number of stored bytes, 0..DEPTH
//   overflow         : sticky, push attempted while full with no pop
//   underflow        : sticky, pop requested while empty
// Modports: master = host/serializer side, slave = FIFO side.
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_TX_FIFO_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic          wr_en;
   uart_byte_t    wr_data;
   logic          flush;
   logic          req;
   logic          err_clr;
   logic          full;
   logic          data_available;
   uart_byte_t    data;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   modport master (
      output wr_en, wr_data, flush, req, err_clr,
      input  full, data_available, data, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, flush, req, err_clr,
      output full, data_available, data, count, overflow, underflow
   );

endinterface : uart_tx_fifo_if

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Simple dual-port byte array: synchronous write, registered read.
// The read register holds its value until the next read enable, so the
// popped byte stays stable for the serializer.
//   clk, rst_n : clock, synchronous active-low reset (clears read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read port, rdata updates on the edge where re is high
//   rdata            : registered read data
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_TX_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  uart_byte_t    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output uart_byte_t    rdata
);

   uart_byte_t mem_q [DEPTH];
   uart_byte_t rdata_q;
   uart_byte_t rdata_d;

   // Storage array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read register only moves on an accepted pop; otherwise it holds.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // A simultaneous write to the same address is seen as the old contents,
   // which is what the full-with-push-and-pop case relies on.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO in front of the UART transmit serializer. Owns pointers, fill
// count and sticky error flags; storage and the popped-byte register live in
// uart_fifo_mem.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uart_tx_fifo_if.slave (push, pop, flush, status and error flags)
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_TX_FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_fifo_if.slave  bus
);

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic full;
   logic not_empty;
   logic pop_req;
   logic pop_ok;
   logic push_ok;
   logic overflow_set;
   logic underflow_set;

   // Status comes only from the registered count, never from pointer compare.
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign not_empty = (count_q != '0);

   // pop_req ignores flush so that a pop alongside a push while full still
   // counts as making room for the overflow decision.
   always_comb begin
      pop_req       = bus.req & not_empty;
      pop_ok        = pop_req & ~bus.flush;
      push_ok       = bus.wr_en & (~full | pop_req) & ~bus.flush;
      overflow_set  = bus.wr_en & full & ~pop_req;
      underflow_set = bus.req & ~not_empty;
   end

   // Pointer and count next-state; flush overrides push and pop.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (bus.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push_ok) begin
            wp_d = wp_q + 1'b1;
         end
         if (pop_ok) begin
            rp_d = rp_q + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Sticky flags: a set event in the same cycle beats err_clr.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (overflow_set) begin
         overflow_d = 1'b1;
      end else if (bus.err_clr) begin
         overflow_d = 1'b0;
      end
      if (underflow_set) begin
         underflow_d = 1'b1;
      end else if (bus.err_clr) begin
         underflow_d = 1'b0;
      end
   end

   // Control state register; reset beats flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q        <= '0;
         rp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push_ok),
      .waddr (wp_q),
      .wdata (bus.wr_data),
      .re    (pop_ok),
      .raddr (rp_q),
      .rdata (bus.data)
   );

   assign bus.full           = full;
   assign bus.data_available = not_empty;
   assign bus.count          = count_q;
   assign bus.overflow       = overflow_q;
   assign bus.underflow      = underflow_q;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks
// the stored bytes, the last popped byte and the sticky flags; every step is
// followed by a full comparison of the DUT outputs against that model, plus
// directed constant checks at the interesting points.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;

   int checkCount;
   int errorCount;

   // Reference model state.
   logic [7:0] modelQ[$];
   logic [7:0] modelData;
   logic       modelOvf;
   logic       modelUnf;

   logic [7:0] savedByte;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single compare point used by every check in the bench.
   task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advances the reference model by one clock edge using the FIFO's rules.
   task automatic modelStep(input logic wr, input logic [7:0] wd, input logic rq,
                            input logic fl, input logic ec, input logic rstn);
      logic hasData, isFull, popReq, ovfSet, unfSet;
      if (!rstn) begin
         modelQ.delete();
         modelData = 8'h00;
         modelOvf  = 1'b0;
         modelUnf  = 1'b0;
      end else begin
         hasData = (modelQ.size() != 0);
         isFull  = (modelQ.size() == DEPTH);
         popReq  = rq && hasData;
         ovfSet  = wr && isFull && !popReq;
         unfSet  = rq && !hasData;
         if (fl) begin
            modelQ.delete();
         end else begin
            if (popReq) modelData = modelQ.pop_front();
            if (wr && (!isFull || popReq)) modelQ.push_back(wd);
         end
         modelOvf = ovfSet ? 1'b1 : (ec ? 1'b0 : modelOvf);
         modelUnf = unfSet ? 1'b1 : (ec ? 1'b0 : modelUnf);
      end
   endtask

   // Drives one cycle of inputs, updates the model at the edge and returns
   // the inputs to idle 1 time unit after the edge.
   task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rq,
                                input logic fl = 1'b0, input logic ec = 1'b0,
                                input logic rstn = 1'b1);
      bus.wr_en   = wr;
      bus.wr_data = wd;
      bus.req     = rq;
      bus.flush   = fl;
      bus.err_clr = ec;
      rst_n       = rstn;
      @(posedge clk);
      modelStep(wr, wd, rq, fl, ec, rstn);
      #1;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.req     = 1'b0;
      bus.flush   = 1'b0;
      bus.err_clr = 1'b0;
      rst_n       = 1'b1;
   endtask

   // Compares every DUT output against the reference model.
   task automatic checkOutput(input string tag);
      checkValue({tag, ".count"}, 16'(bus.count), 16'(modelQ.size()));
      checkValue({tag, ".full"}, 16'(bus.full), 16'(modelQ.size() == DEPTH));
      checkValue({tag, ".avail"}, 16'(bus.data_available), 16'(modelQ.size() != 0));
      checkValue({tag, ".data"}, 16'(bus.data), 16'(modelData));
      checkValue({tag, ".ovf"}, 16'(bus.overflow), 16'(modelOvf));
      checkValue({tag, ".unf"}, 16'(bus.underflow), 16'(modelUnf));
   endtask

   task automatic stepAndCheck(input string tag, input logic wr, input logic [7:0] wd,
                               input logic rq, input logic fl = 1'b0,
                               input logic ec = 1'b0, input logic rstn = 1'b1);
      applyStimulus(wr, wd, rq, fl, ec, rstn);
      checkOutput(tag);
   endtask

   initial begin
      checkCount  = 0;
      errorCount  = 0;
      modelData   = 8'h00;
      modelOvf    = 1'b0;
      modelUnf    = 1'b0;
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.req     = 1'b0;
      bus.flush   = 1'b0;
      bus.err_clr = 1'b0;

      // Reset
      stepAndCheck("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      stepAndCheck("rst1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      checkValue("rst.count", 16'(bus.count), 16'd0);
      checkValue("rst.data", 16'(bus.data), 16'h00);

      // Two pushes, two spaced pops
      stepAndCheck("push_a5", 1'b1, 8'hA5, 1'b0);
      checkValue("push_a5.avail", 16'(bus.data_available), 16'd1);
      stepAndCheck("push_3c", 1'b1, 8'h3C, 1'b0);
      checkValue("two.count", 16'(bus.count), 16'd2);
      stepAndCheck("pop1", 1'b0, 8'h00, 1'b1);
      checkValue("pop1.data", 16'(bus.data), 16'hA5);
      stepAndCheck("hold1", 1'b0, 8'h00, 1'b0);
      stepAndCheck("hold2", 1'b0, 8'h00, 1'b0);
      checkValue("hold.data", 16'(bus.data), 16'hA5);
      stepAndCheck("pop2", 1'b0, 8'h00, 1'b1);
      checkValue("pop2.data", 16'(bus.data), 16'h3C);
      checkValue("pop2.count", 16'(bus.count), 16'd0);

      // Fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) stepAndCheck("fill", 1'b1, 8'(i), 1'b0);
      checkValue("fill.full", 16'(bus.full), 16'd1);
      stepAndCheck("ovf_push", 1'b1, 8'hFF, 1'b0);
      checkValue("ovf.flag", 16'(bus.overflow), 16'd1);
      checkValue("ovf.count", 16'(bus.count), 16'd16);
      for (int i = 0; i < DEPTH; i++) begin
         stepAndCheck("drain", 1'b0, 8'h00, 1'b1);
         checkValue("drain.order", 16'(bus.data), 16'(i));
      end

      // Full with simultaneous push and pop
      stepAndCheck("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) stepAndCheck("refill", 1'b1, 8'(8'h40 + i), 1'b0);
      stepAndCheck("full_both", 1'b1, 8'h77, 1'b1);
      checkValue("full_both.count", 16'(bus.count), 16'd16);
      checkValue("full_both.ovf", 16'(bus.overflow), 16'd0);
      for (int i = 0; i < DEPTH; i++) stepAndCheck("drain2", 1'b0, 8'h00, 1'b1);
      checkValue("drain2.last", 16'(bus.data), 16'h77);

      // Underflow and empty push+pop
      savedByte = bus.data;
      stepAndCheck("unf", 1'b0, 8'h00, 1'b1);
      checkValue("unf.flag", 16'(bus.underflow), 16'd1);
      checkValue("unf.data", 16'(bus.data), 16'(savedByte));
      stepAndCheck("empty_both", 1'b1, 8'h11, 1'b1);
      checkValue("empty_both.count", 16'(bus.count), 16'd1);
      stepAndCheck("pop11", 1'b0, 8'h00, 1'b1);
      checkValue("pop11.data", 16'(bus.data), 16'h11);
      stepAndCheck("errclr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkValue("errclr.unf", 16'(bus.underflow), 16'd0);

      // Flush with a concurrent write
      for (int i = 0; i < 5; i++) stepAndCheck("p5", 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      stepAndCheck("pop_a", 1'b0, 8'h00, 1'b1);
      stepAndCheck("pop_b", 1'b0, 8'h00, 1'b1);
      savedByte = modelData;
      stepAndCheck("flush_wr", 1'b1, 8'hEE, 1'b0, 1'b1);
      checkValue("flush.count", 16'(bus.count), 16'd0);
      checkValue("flush.data", 16'(bus.data), 16'(savedByte));

      // Interleaved traffic across pointer wrap
      for (int i = 0; i < 20; i++)
         stepAndCheck("wrap", 1'b1, 8'($urandom_range(0, 255)), 1'(i % 2));
      for (int i = 0; i < 12; i++) stepAndCheck("wrap_drain", 1'b0, 8'h00, 1'b1);

      // Half-full with overflow, then reset together with flush
      for (int i = 0; i < DEPTH + 1; i++) stepAndCheck("hf_fill", 1'b1, 8'(8'h80 + i), 1'b0);
      for (int i = 0; i < 8; i++) stepAndCheck("hf_pop", 1'b0, 8'h00, 1'b1);
      checkValue("hf.ovf", 16'(bus.overflow), 16'd1);
      stepAndCheck("rst_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      checkValue("rst_flush.count", 16'(bus.count), 16'd0);
      checkValue("rst_flush.data", 16'(bus.data), 16'h00);
      checkValue("rst_flush.ovf", 16'(bus.overflow), 16'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         stepAndCheck("rand",
                      1'($urandom_range(0, 99) < 55),
                      8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 99) < 45),
                      1'($urandom_range(0, 39) == 0),
                      1'($urandom_range(0, 19) == 0),
                      1'($urandom_range(0, 99) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule : tb_uart_tx_fifo
